// File: rtl/pipeline_exe_multicycle_if.sv
// ID->EXE->MEM stage bundle for pipeline_exe_multicycle. XLEN/RIDX_W must match the
// parameters of the module it is connected to.
interface pipeline_exe_multicycle_if #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
);
    // Handshake: an instruction moves from ID into EXE on a rising edge where
    // valid_d_i && ready_e_o. valid_d_i may not depend on ready_e_o. stall_m_i holds
    // the EXE outputs. flush_i kills the in-flight op, the outputs and any same-cycle transfer.
    logic              valid_d_i;
    logic              ready_e_o;
    logic              flush_i;
    logic              stall_m_i;
    logic [4:0]        alu_op_d_i;
    logic [XLEN-1:0]   rs1_d_i;
    logic [XLEN-1:0]   rs2_d_i;
    logic [XLEN-1:0]   extended_imm_d_i;
    logic [XLEN-1:0]   pc_plus4_d_i;
    logic [2:0]        dmem_type_d_i;
    logic              reg_write_en_d_i;
    logic [RIDX_W-1:0] rd_idx_d_i;
    logic [1:0]        result_src_d_i;
    logic              instr_illegal_d_i;

    logic              valid_e_o;
    logic [XLEN-1:0]   alu_result_e_o;
    logic [XLEN-1:0]   extended_imm_e_o;
    logic [XLEN-1:0]   pc_plus4_e_o;
    logic [2:0]        dmem_type_e_o;
    logic              reg_write_en_e_o;
    logic [RIDX_W-1:0] rd_idx_e_o;
    logic [1:0]        result_src_e_o;
    logic              instr_illegal_e_o;
    logic              busy_e_o;
    logic [1:0]        dbg_state_o;

    modport master (
        output valid_d_i, flush_i, stall_m_i, alu_op_d_i, rs1_d_i, rs2_d_i,
               extended_imm_d_i, pc_plus4_d_i, dmem_type_d_i, reg_write_en_d_i,
               rd_idx_d_i, result_src_d_i, instr_illegal_d_i,
        input  ready_e_o, valid_e_o, alu_result_e_o, extended_imm_e_o, pc_plus4_e_o,
               dmem_type_e_o, reg_write_en_e_o, rd_idx_e_o, result_src_e_o,
               instr_illegal_e_o, busy_e_o, dbg_state_o
    );

    modport slave (
        input  valid_d_i, flush_i, stall_m_i, alu_op_d_i, rs1_d_i, rs2_d_i,
               extended_imm_d_i, pc_plus4_d_i, dmem_type_d_i, reg_write_en_d_i,
               rd_idx_d_i, result_src_d_i, instr_illegal_d_i,
        output ready_e_o, valid_e_o, alu_result_e_o, extended_imm_e_o, pc_plus4_e_o,
               dmem_type_e_o, reg_write_en_e_o, rd_idx_e_o, result_src_e_o,
               instr_illegal_e_o, busy_e_o, dbg_state_o
    );
endinterface

// File: rtl/pipeline_exe_multicycle.sv
// Execute stage: single-cycle ALU plus an optional radix-2 MUL/DIV unit (XLEN+1 cycles).
// The MUL/DIV unit and its FSM are built only when EXE_MULDIV_EN is defined.
module pipeline_exe_multicycle #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_exe_multicycle_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;

    typedef struct packed {
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc4;
        logic [2:0]        dmem;
        logic              rwe;
        logic [RIDX_W-1:0] rd;
        logic [1:0]        rsrc;
        logic              illegal;
    } side_t;

    side_t           side_in;
    logic [XLEN-1:0] a, b, alu_res;
    logic [SH_W-1:0] shamt;
    logic            op_is_md, ready, xfer;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    side_t           md_side;
    state_e          state_q;

    assign a        = bus.rs1_d_i;
    assign b        = bus.rs2_d_i;
    assign shamt    = b[SH_W-1:0];
    assign op_is_md = (bus.alu_op_d_i[4:3] == 2'b10);
    assign ready    = (state_q == S_IDLE) && !bus.stall_m_i && !reset;
    assign xfer     = bus.valid_d_i && ready;

    always_comb begin
        side_in.imm     = bus.extended_imm_d_i;
        side_in.pc4     = bus.pc_plus4_d_i;
        side_in.dmem    = bus.dmem_type_d_i;
        side_in.rwe     = bus.reg_write_en_d_i;
        side_in.rd      = bus.rd_idx_d_i;
        side_in.rsrc    = bus.result_src_d_i;
        side_in.illegal = bus.instr_illegal_d_i;
    end

    always_comb begin
        alu_res = a + b;
        case (bus.alu_op_d_i)
            5'd1:    alu_res = a - b;
            5'd2:    alu_res = a << shamt;
            5'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            5'd4:    alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            5'd5:    alu_res = a ^ b;
            5'd6:    alu_res = a >> shamt;
            5'd7:    alu_res = $signed(a) >>> shamt;
            5'd8:    alu_res = a | b;
            5'd9:    alu_res = a & b;
            default: alu_res = a + b;
        endcase
    end

`ifdef EXE_MULDIV_EN
    localparam bit MD_EN = 1'b1;

    state_e            state_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic              mul_q, mul_d, sel_hi_q, sel_hi_d, neg_q, neg_d, div0_q, div0_d;
    side_t             side_q, side_d;
    logic [2:0]        md_op;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum, div_shift;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot, rem;

    assign md_op = bus.alu_op_d_i[2:0];
    assign a_neg = a[XLEN-1] && (md_op == 3'd1 || md_op == 3'd2 || md_op == 3'd4 || md_op == 3'd6);
    assign b_neg = b[XLEN-1] && (md_op == 3'd1 || md_op == 3'd4 || md_op == 3'd6);
    assign abs_a = a_neg ? -a : a;
    assign abs_b = b_neg ? -b : b;

    // Both units run on magnitudes: hi/lo is the product (MUL) or remainder/quotient (DIV).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        mul_d     = mul_q;
        sel_hi_d  = sel_hi_q;
        neg_d     = neg_q;
        div0_d    = div0_q;
        side_d    = side_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        div_shift = {hi_q, lo_q[XLEN-1]};
        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (xfer && op_is_md) begin
                    state_d  = S_BUSY;
                    cnt_d    = '0;
                    hi_d     = '0;
                    lo_d     = abs_a;
                    opb_d    = abs_b;
                    mul_d    = !md_op[2];
                    sel_hi_d = md_op[2] ? md_op[1] : (md_op[1:0] != 2'd0);
                    neg_d    = (md_op[2] && md_op[1]) ? a_neg : (a_neg ^ b_neg);
                    div0_d   = (b == '0);
                    side_d   = side_in;
                end
                S_BUSY: begin
                    cnt_d = cnt_q + 1'b1;
                    if (mul_q) begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end else if (div_shift >= {1'b0, opb_q}) begin
                        hi_d = div_shift[XLEN-1:0] - opb_q;
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == SH_W'(XLEN-1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end
                S_DONE:  if (!bus.stall_m_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            mul_q    <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            side_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            mul_q    <= mul_d;
            sel_hi_q <= sel_hi_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            side_q   <= side_d;
        end
    end

    // Divide by zero: quotient all-ones; the remainder sign fix-up restores the dividend.
    assign prod_s    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quot      = div0_q ? '1 : (neg_q ? -lo_q : lo_q);
    assign rem       = neg_q ? -hi_q : hi_q;
    assign md_result = mul_q ? (sel_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0])
                             : (sel_hi_q ? rem : quot);
    assign md_done   = (state_q == S_DONE);
    assign md_side   = side_q;
`else
    localparam bit MD_EN = 1'b0;

    assign state_q   = S_IDLE;
    assign md_done   = 1'b0;
    assign md_result = '0;
    assign md_side   = '0;
`endif

    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    side_t           out_q, out_d;

    // Without the MUL/DIV unit, codes 16-23 complete at once as illegal with result 0.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        out_d    = out_q;
        if (bus.flush_i) begin
            valid_d   = 1'b0;
            out_d.rwe = 1'b0;
        end else if (bus.stall_m_i) begin
            valid_d = valid_q;
        end else if (md_done) begin
            valid_d  = 1'b1;
            result_d = md_result;
            out_d    = md_side;
        end else if (xfer && !(MD_EN && op_is_md)) begin
            valid_d       = 1'b1;
            result_d      = op_is_md ? '0 : alu_res;
            out_d         = side_in;
            out_d.illegal = side_in.illegal | op_is_md;
        end else begin
            valid_d   = 1'b0;
            out_d.rwe = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            out_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            out_q    <= out_d;
        end
    end

    assign bus.ready_e_o         = ready;
    assign bus.valid_e_o         = valid_q;
    assign bus.alu_result_e_o    = result_q;
    assign bus.extended_imm_e_o  = out_q.imm;
    assign bus.pc_plus4_e_o      = out_q.pc4;
    assign bus.dmem_type_e_o     = out_q.dmem;
    assign bus.reg_write_en_e_o  = out_q.rwe;
    assign bus.rd_idx_e_o        = out_q.rd;
    assign bus.result_src_e_o    = out_q.rsrc;
    assign bus.instr_illegal_e_o = out_q.illegal;
    assign bus.busy_e_o          = (state_q != S_IDLE);
    assign bus.dbg_state_o       = state_q;
endmodule

// File: tb/tb_pipeline_exe_multicycle.sv
// Directed bench for pipeline_exe_multicycle; covers the MUL/DIV unit when EXE_MULDIV_EN is defined.
module tb_pipeline_exe_multicycle;
    localparam int XLEN   = 32;
    localparam int RIDX_W = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_exe_multicycle_if #(.XLEN(XLEN), .RIDX_W(RIDX_W)) bus ();
    pipeline_exe_multicycle #(.XLEN(XLEN), .RIDX_W(RIDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.valid_d_i         = 1'b0;
        bus.flush_i           = 1'b0;
        bus.stall_m_i         = 1'b0;
        bus.alu_op_d_i        = '0;
        bus.rs1_d_i           = '0;
        bus.rs2_d_i           = '0;
        bus.extended_imm_d_i  = '0;
        bus.pc_plus4_d_i      = '0;
        bus.dmem_type_d_i     = '0;
        bus.reg_write_en_d_i  = 1'b0;
        bus.rd_idx_d_i        = '0;
        bus.result_src_d_i    = '0;
        bus.instr_illegal_d_i = 1'b0;
    endtask

    task automatic drive_op(input logic [4:0] op, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [RIDX_W-1:0] rd);
        bus.valid_d_i         = 1'b1;
        bus.alu_op_d_i        = op;
        bus.rs1_d_i           = a;
        bus.rs2_d_i           = b;
        bus.extended_imm_d_i  = 32'h1000 + 32'(rd);
        bus.pc_plus4_d_i      = 32'h4000 + 32'(rd) * 4;
        bus.dmem_type_d_i     = rd[2:0];
        bus.reg_write_en_d_i  = 1'b1;
        bus.rd_idx_d_i        = rd;
        bus.result_src_d_i    = rd[1:0];
        bus.instr_illegal_d_i = 1'b0;
    endtask

`ifdef EXE_MULDIV_EN
    // Transfer at T0, scramble the ID inputs, expect the result exactly at T0+XLEN+1.
    task automatic md_run(input string tag, input logic [4:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        logic bad;
        logic [RIDX_W-1:0] rd;
        rd = RIDX_W'($urandom_range(1, 31));
        drive_op(op, a, b, rd);
        exp_q.push_back(exp);
        tick();
        chk({tag, "_start"}, {bus.ready_e_o, bus.busy_e_o, bus.valid_e_o}, 3'b010);
        bus.rs1_d_i    = $urandom;
        bus.rs2_d_i    = $urandom;
        bus.rd_idx_d_i = RIDX_W'($urandom_range(0, 31));
        bad = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            tick();
            if (bus.valid_e_o || bus.ready_e_o || !bus.busy_e_o) bad = 1'b1;
        end
        chk({tag, "_wait"}, bad, 1'b0);
        drive_idle();
        tick();
        chk({tag, "_res"}, bus.alu_result_e_o, exp_q.pop_front());
        chk({tag, "_vld"}, {bus.valid_e_o, bus.busy_e_o, bus.ready_e_o, bus.rd_idx_e_o}, {3'b101, rd});
    endtask

    task automatic watch_quiet(input string tag);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.valid_e_o || bus.busy_e_o) bad = 1'b1;
        end
        chk(tag, bad, 1'b0);
    endtask
`endif

    logic [4:0]      v_op [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd31};
    logic [XLEN-1:0] v_a  [12] = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                                   32'h80000000, 32'h80000000, 32'h12340000, 32'hF0F0F0F0, 32'h5, 32'h7};
    logic [XLEN-1:0] v_b  [12] = '{32'h1, 32'h1, 32'h21, 32'h1, 32'h1, 32'hFF00FF00,
                                   32'h24, 32'h24, 32'h00005678, 32'hFF00FF00, 32'h6, 32'h8};
    logic [XLEN-1:0] v_exp[12] = '{32'h0, 32'hFFFFFFFF, 32'h2, 32'h1, 32'h0, 32'h0FF00FF0,
                                   32'h08000000, 32'hF8000000, 32'h12345678, 32'hF000F000, 32'hB, 32'hF};

    initial begin
        logic frozen;
        drive_idle();
        reset = 1'b1;
        drive_op(5'd0, 32'd1, 32'd2, 5'd3);
        tick();
        tick();
        chk("rst_valid", bus.valid_e_o, 1'b0);
        chk("rst_result", bus.alu_result_e_o, 32'h0);
        chk("rst_side", {bus.reg_write_en_e_o, bus.rd_idx_e_o, bus.pc_plus4_e_o, bus.instr_illegal_e_o}, '0);
        chk("rst_ready_busy", {bus.ready_e_o, bus.busy_e_o}, 2'b00);
        reset = 1'b0;
        drive_idle();
        #1;
        chk("ready_after_rst", bus.ready_e_o, 1'b1);

        for (int i = 0; i < 12; i++) begin
            drive_op(v_op[i], v_a[i], v_b[i], RIDX_W'(i + 1));
            exp_q.push_back(v_exp[i]);
            tick();
            chk($sformatf("alu%0d_res", i), bus.alu_result_e_o, exp_q.pop_front());
            chk($sformatf("alu%0d_vld", i), {bus.valid_e_o, bus.rd_idx_e_o}, {1'b1, RIDX_W'(i + 1)});
        end
        chk("side_pass", {bus.extended_imm_e_o, bus.pc_plus4_e_o},
            {32'h100C, 32'h4030});
        chk("side_misc", {bus.dmem_type_e_o, bus.result_src_e_o, bus.reg_write_en_e_o, bus.instr_illegal_e_o},
            {3'd4, 2'd0, 1'b1, 1'b0});

        drive_idle();
        tick();
        chk("bubble", {bus.valid_e_o, bus.reg_write_en_e_o}, 2'b00);

        drive_op(5'd0, 32'd100, 32'd23, 5'd7);
        tick();
        chk("stall_pre", bus.alu_result_e_o, 32'd123);
        drive_op(5'd1, 32'd9, 32'd4, 5'd8);
        bus.stall_m_i = 1'b1;
        #1;
        chk("stall_ready", bus.ready_e_o, 1'b0);
        frozen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.alu_result_e_o !== 32'd123 || bus.valid_e_o !== 1'b1 ||
                bus.rd_idx_e_o !== 5'd7 || bus.ready_e_o !== 1'b0) frozen = 1'b0;
        end
        chk("stall_frozen", frozen, 1'b1);
        bus.stall_m_i = 1'b0;
        #1;
        chk("stall_release_ready", bus.ready_e_o, 1'b1);
        tick();
        chk("stall_next_op", {bus.alu_result_e_o, bus.rd_idx_e_o, bus.valid_e_o}, {32'd5, 5'd8, 1'b1});

        drive_op(5'd0, 32'd1, 32'd1, 5'd9);
        bus.flush_i = 1'b1;
        tick();
        chk("flush_kill", {bus.valid_e_o, bus.reg_write_en_e_o}, 2'b00);
        bus.flush_i = 1'b0;
        tick();
        chk("flush_after", {bus.alu_result_e_o, bus.valid_e_o}, {32'd2, 1'b1});
        bus.stall_m_i = 1'b1;
        bus.flush_i   = 1'b1;
        tick();
        chk("flush_over_stall", {bus.valid_e_o, bus.reg_write_en_e_o}, 2'b00);
        drive_idle();

`ifndef EXE_MULDIV_EN
        drive_op(5'd16, 32'd3, 32'd4, 5'd3);
        tick();
        chk("nomd_mul", {bus.valid_e_o, bus.alu_result_e_o, bus.instr_illegal_e_o}, {1'b1, 32'd0, 1'b1});
        chk("nomd_ready", {bus.ready_e_o, bus.busy_e_o}, 2'b10);
        drive_op(5'd20, 32'd10, 32'd2, 5'd4);
        tick();
        chk("nomd_div", {bus.valid_e_o, bus.alu_result_e_o, bus.instr_illegal_e_o, bus.rd_idx_e_o},
            {1'b1, 32'd0, 1'b1, 5'd4});
        drive_idle();
        tick();
`else
        md_run("mulhu", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        md_run("mul", 5'd16, 32'd3, 32'd4, 32'd12);
        md_run("mulh", 5'd17, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
        md_run("mulhsu", 5'd18, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
        md_run("div_ovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        md_run("rem_ovf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        md_run("divu_z", 5'd21, 32'd7, 32'd0, 32'hFFFFFFFF);
        md_run("remu_z", 5'd23, 32'd7, 32'd0, 32'd7);
        md_run("div_neg", 5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        md_run("rem_neg", 5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        md_run("divu", 5'd21, 32'd100, 32'd7, 32'd14);
        md_run("remu", 5'd23, 32'd100, 32'd7, 32'd2);
        md_run("div_z", 5'd20, 32'd5, 32'd0, 32'hFFFFFFFF);
        md_run("rem_z", 5'd22, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);

        drive_op(5'd21, 32'd100, 32'd7, 5'd5);
        tick();
        drive_idle();
        repeat (10) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        #1;
        chk("md_flush", {bus.valid_e_o, bus.busy_e_o, bus.ready_e_o}, 3'b001);
        watch_quiet("md_flush_stale");

        drive_op(5'd21, 32'd100, 32'd7, 5'd6);
        tick();
        drive_idle();
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("md_reset", {bus.valid_e_o, bus.busy_e_o, bus.ready_e_o}, 3'b001);
        watch_quiet("md_reset_stale");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pipeline_exe_multicycle.md
PIPELINE_EXE_MULTICYCLE -- requirements
Module: pipeline_exe_multicycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have parameter RIDX_W, default 5, register index width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports valid_d_i in 1 (ID holds a valid instr), ready_e_o out 1 (EXE accepts this cycle), flush_i in 1 (kill in-flight and output), stall_m_i in 1 (MEM cannot accept).
REQ-006 SHALL have data inputs alu_op_d_i in 5, rs1_d_i in XLEN, rs2_d_i in XLEN, extended_imm_d_i in XLEN, pc_plus4_d_i in XLEN.
REQ-007 SHALL have sideband inputs dmem_type_d_i in 3, reg_write_en_d_i in 1, rd_idx_d_i in RIDX_W, result_src_d_i in 2, instr_illegal_d_i in 1.
REQ-008 SHALL have registered outputs valid_e_o 1, alu_result_e_o XLEN, extended_imm_e_o XLEN, pc_plus4_e_o XLEN, dmem_type_e_o 3, reg_write_en_e_o 1, rd_idx_e_o RIDX_W, result_src_e_o 2, instr_illegal_e_o 1, plus busy_e_o 1 (multicycle op in progress).

Function
REQ-009 SHALL decode alu_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; any other code computes ADD.
REQ-010 SHALL use shift amount rs2[log2(XLEN)-1:0]; results wrap modulo 2^XLEN; SLT/SLTU yield 0 or 1.
REQ-011 SHALL assert ready_e_o = (state==IDLE) && !stall_m_i && !reset; a transfer occurs when valid_d_i && ready_e_o.
REQ-012 SHALL, for a transferred single-cycle op (codes 0-9 and undefined), load all output registers and set valid_e_o=1 at the same edge (latency 1).
REQ-013 SHALL, on a cycle with no transfer and !stall_m_i and no result completing, set valid_e_o=0 and reg_write_en_e_o=0 (bubble).
REQ-014 SHALL hold every output register unchanged while stall_m_i=1, unless flush_i=1.
REQ-015 SHALL implement FSM IDLE -> BUSY on transfer of op 16-23; BUSY holds XLEN cycles, one radix-2 iteration per cycle, counter 0..XLEN-1; BUSY -> DONE at the edge where counter==XLEN-1; DONE -> IDLE when !stall_m_i, loading outputs with valid_e_o=1 at that edge.
REQ-016 SHALL latch operands and all sideband inputs at transfer; input changes during BUSY/DONE SHALL not affect the result.
REQ-017 SHALL drive busy_e_o=1 in BUSY and DONE; an unstalled MUL/DIV result is valid at edge T0+XLEN+1, T0 being the transfer edge.
REQ-018 SHALL return, for divide by zero, quotient all-ones and remainder = dividend, after full latency.
REQ-019 SHALL return, for DIV/REM with dividend -2^(XLEN-1) and divisor -1, quotient -2^(XLEN-1) and remainder 0.
REQ-020 SHALL, when flush_i=1, at the next edge set valid_e_o=0, reg_write_en_e_o=0, FSM to IDLE, discard any same-cycle transfer; flush overrides stall_m_i.
REQ-021 SHALL give priority reset > flush_i > stall_m_i > completion/transfer.

Reset
REQ-022 SHALL, while reset=1 at an edge, clear every output register to 0, FSM to IDLE, counter to 0.
REQ-023 SHALL abort any in-progress MUL/DIV on reset with no result emitted.

Configuration
REQ-024 SHALL compile the MUL/DIV unit and FSM only when macro EXE_MULDIV_EN is defined.
REQ-025 SHALL, without EXE_MULDIV_EN, treat codes 16-23 as single-cycle with alu_result_e_o=0 and instr_illegal_e_o=1; busy_e_o tied 0.

Verification
REQ-026 SHALL cover ADD rs1=0xFFFFFFFF rs2=1 -> next edge alu_result_e_o=0x00000000, valid_e_o=1.
REQ-027 SHALL cover SRA rs1=0x80000000 rs2=0x24 -> 0xF8000000; SLT rs1=0xFFFFFFFF rs2=1 -> 1; SLTU same -> 0.
REQ-028 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> ready_e_o low 33 cycles, result 0xFFFFFFFE at T0+33; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REMU 7/0 -> 7.
REQ-029 SHALL cover stall_m_i=1 for 5 cycles after ADD result -> outputs frozen, ready_e_o=0, then next op accepted on release.
REQ-030 SHALL cover flush_i pulse at BUSY counter=10 of DIVU -> valid_e_o=0 next edge, ready_e_o=1, no stale result; reset mid-BUSY -> same.
REQ-031 SHALL cover EXE_MULDIV_EN undefined: MUL 3x4 -> next edge alu_result_e_o=0, instr_illegal_e_o=1.
